// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns engine.
// Accepts one 128-bit state over a valid/ready handshake and transforms
// COLS_PER_CYCLE columns per clock. The result is held on a registered
// valid/ready output until it is consumed.
// Byte i of a state is bits [8i+7:8i]; column c holds bytes 4c..4c+3, and
// byte 4c+r is row r of that column.
module inv_mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Counter increment per BUSY cycle. For four columns per cycle this is
    // 0 mod 4, which is harmless because that single pass is also the last.
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    // Counter value at the start of the pass that finishes column 3.
    localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

    state_e       state_q;
    logic [1:0]   cnt_q;
    logic [127:0] work_q;
    logic [127:0] result_q;
    logic [127:0] result_d;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;
    logic         last_s;

    // GF(2^8) doubling under the polynomial x^8 + x^4 + x^3 + x + 1 (0x11B).
    function automatic logic [7:0] gf_dbl(input logic [7:0] x);
        gf_dbl = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // 9x = 8x ^ x
    function automatic logic [7:0] gf_mul9(input logic [7:0] x);
        gf_mul9 = gf_dbl(gf_dbl(gf_dbl(x))) ^ x;
    endfunction

    // 11x = 8x ^ 2x ^ x
    function automatic logic [7:0] gf_mul11(input logic [7:0] x);
        gf_mul11 = gf_dbl(gf_dbl(gf_dbl(x))) ^ gf_dbl(x) ^ x;
    endfunction

    // 13x = 8x ^ 4x ^ x
    function automatic logic [7:0] gf_mul13(input logic [7:0] x);
        gf_mul13 = gf_dbl(gf_dbl(gf_dbl(x))) ^ gf_dbl(gf_dbl(x)) ^ x;
    endfunction

    // 14x = 8x ^ 4x ^ 2x
    function automatic logic [7:0] gf_mul14(input logic [7:0] x);
        gf_mul14 = gf_dbl(gf_dbl(gf_dbl(x))) ^ gf_dbl(gf_dbl(x)) ^ gf_dbl(x);
    endfunction

    // InvMixColumns of one column; row r sits in bits [8r+7:8r].
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        logic [7:0] o0;
        logic [7:0] o1;
        logic [7:0] o2;
        logic [7:0] o3;
        a0 = col[7:0];
        a1 = col[15:8];
        a2 = col[23:16];
        a3 = col[31:24];
        o0 = gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3);
        o1 = gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3);
        o2 = gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3);
        o3 = gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3);
        inv_mix_col = {o3, o2, o1, o0};
    endfunction

    assign last_s = (cnt_q == CNT_LAST);

    // Column engine: transform the columns selected by the counter, keep the rest.
    always_comb begin
        logic [1:0] col_idx;
        col_idx  = 2'b00;
        result_d = result_q;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            col_idx = cnt_q + 2'(k);
            result_d[{col_idx, 5'b00000} +: 32] = inv_mix_col(work_q[{col_idx, 5'b00000} +: 32]);
        end
    end

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            work_q      <= 128'd0;
            result_q    <= 128'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        work_q     <= data_in;
                        cnt_q      <= 2'd0;
                        state_q    <= ST_BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    result_q <= result_d;
                    if (last_s) begin
                        // Column 3 is written on this edge: present the result.
                        cnt_q       <= 2'd0;
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_STEP;
                    end
                end
                ST_DONE: begin
                    // Input is never accepted here; it waits for IDLE next cycle.
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean idle state.
                    state_q     <= ST_IDLE;
                    cnt_q       <= 2'd0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign data_out  = result_q;

endmodule
